// File: rtl/hazard_scoreboard.sv
// ----------------------------------------------------------------------------
// hazard_scoreboard: per-register write tracking and ID-stage stall control.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module hazard_scoreboard #(
  parameter int WB_LAT           = 3,
  parameter int RF_WRITE_THROUGH = 1,
  parameter int NREGS            = 32,
  parameter int STAT_W           = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [31:0]       id_inst,
  output logic              issue,
  output logic              stall,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              idex_bubble,
  output logic [NREGS-1:0]  pending_mask,
  output logic [STAT_W-1:0] stall_count
);

  localparam int              CNT_W   = $clog2(WB_LAT + 1);
  localparam logic [CNT_W-1:0] C_LAT  = CNT_W'(WB_LAT);
  localparam logic [CNT_W-1:0] C_BUSY = CNT_W'((RF_WRITE_THROUGH != 0) ? 1 : 0);

  logic [5:0] w_op;
  logic [4:0] w_rs, w_rt, w_rd;
  logic       unused_inst_bits;

  assign w_op             = id_inst[31:26];
  assign w_rs             = id_inst[25:21];
  assign w_rt             = id_inst[20:16];
  assign w_rd             = id_inst[15:11];
  assign unused_inst_bits = ^id_inst[10:0];

  logic [CNT_W-1:0] cnt_q [NREGS];
  logic [CNT_W-1:0] cnt_d [NREGS];

  logic w_is_alu, w_writes, w_busy_rs, w_busy_rt;
  logic [NREGS-1:0] w_load;

  assign w_is_alu  = (w_op >= 6'd1) && (w_op <= 6'd4);
  assign w_writes  = w_is_alu && (w_rd != 5'd0);
  assign w_busy_rs = cnt_q[w_rs] > C_BUSY;
  assign w_busy_rt = cnt_q[w_rt] > C_BUSY;

  // Gated by rst so an asserted reset releases a held instruction immediately.
  assign stall       = ~rst & id_valid & (w_op != 6'd0) & (w_busy_rs | w_busy_rt);
  assign issue       = ~rst & id_valid & ~stall;
  assign pc_write    = ~stall;
  assign ifid_write  = ~stall;
  assign idex_bubble = stall;

  assign w_load = (issue && w_writes) ? (NREGS'(1) << w_rd) : '0;

  generate
    for (genvar gi = 0; gi < NREGS; gi++) begin : g_cnt
      // A fresh issue to rd overrides its decrement: youngest write wins.
      always_comb begin
        cnt_d[gi] = cnt_q[gi];
        if (w_load[gi]) begin
          cnt_d[gi] = C_LAT;
        end else if (cnt_q[gi] != '0) begin
          cnt_d[gi] = cnt_q[gi] - CNT_W'(1);
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_q[gi] <= '0;
        end else begin
          cnt_q[gi] <= cnt_d[gi];
        end
      end

      assign pending_mask[gi] = (cnt_q[gi] != '0);
    end
  endgenerate

  logic [STAT_W-1:0] stall_count_q, stall_count_d;

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
// ----------------------------------------------------------------------------
// tb_hazard_scoreboard: directed self-checking bench for hazard_scoreboard.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_hazard_scoreboard;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [31:0] id_inst;
  logic        issue, stall, pc_write, ifid_write, idex_bubble;
  logic [31:0] pending_mask;
  logic [15:0] stall_count;
  logic        s_issue, s_stall, s_pc_write, s_ifid_write, s_idex_bubble;
  logic [31:0] s_pending_mask;
  logic [3:0]  s_stall_count;

  int errors = 0;
  int checks = 0;
  int exp_sc = 0;

  hazard_scoreboard dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_inst(id_inst),
    .issue(issue), .stall(stall), .pc_write(pc_write), .ifid_write(ifid_write),
    .idex_bubble(idex_bubble), .pending_mask(pending_mask), .stall_count(stall_count)
  );

  // Narrow statistics counter so saturation is reachable in a short run.
  hazard_scoreboard #(.STAT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_inst(id_inst),
    .issue(s_issue), .stall(s_stall), .pc_write(s_pc_write), .ifid_write(s_ifid_write),
    .idex_bubble(s_idex_bubble), .pending_mask(s_pending_mask), .stall_count(s_stall_count)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1);
  end

  function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs, input logic [4:0] rt);
    return {op, rs, rt, rd, 11'd0};
  endfunction

  task automatic drive(input logic v, input logic [31:0] inst);
    id_valid = v;
    id_inst  = inst;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    drive(1'b0, 32'd0);
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, enc(6'd3, 5'd5, 5'd3, 5'd4));
    #40;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b want 0", stall); end
    checks++; if (issue !== 1'b0) begin errors++; $display("FAIL rst_issue: got %b want 0", issue); end
    checks++; if (pc_write !== 1'b1 || ifid_write !== 1'b1) begin errors++; $display("FAIL rst_write_en: got %b%b want 11", pc_write, ifid_write); end
    checks++; if (idex_bubble !== 1'b0) begin errors++; $display("FAIL rst_bubble: got %b want 0", idex_bubble); end
    checks++; if (pending_mask !== 32'd0) begin errors++; $display("FAIL rst_mask: got %h want 0", pending_mask); end
    checks++; if (stall_count !== 16'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", stall_count); end
    #45;
    rst = 1'b0;
    drain();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, enc(6'd1, 5'd3, 5'd1, 5'd2));
    #1;
    checks++; if (issue !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL b2b_add_issue: got issue=%b stall=%b want 1/0", issue, stall); end
    tick();
    drive(1'b1, 32'd0);
    #1;
    checks++; if (pending_mask !== 32'h8 || stall !== 1'b0) begin errors++; $display("FAIL b2b_nop: got mask=%h stall=%b want 8/0", pending_mask, stall); end
    tick();
    drive(1'b1, enc(6'd2, 5'd4, 5'd2, 5'd3));
    #1;
    checks++; if (stall !== 1'b1 || idex_bubble !== 1'b1 || pc_write !== 1'b0 || issue !== 1'b0) begin
      errors++; $display("FAIL b2b_sub_stall: got stall=%b bub=%b pcw=%b issue=%b want 1/1/0/0", stall, idex_bubble, pc_write, issue); end
    exp_sc++;
    tick();
    #1;
    checks++; if (stall !== 1'b0 || issue !== 1'b1 || pending_mask !== 32'h8) begin
      errors++; $display("FAIL b2b_sub_issue: got stall=%b issue=%b mask=%h want 0/1/8", stall, issue, pending_mask); end
    checks++; if (stall_count !== 16'(exp_sc)) begin errors++; $display("FAIL b2b_count: got %0d want %0d", stall_count, exp_sc); end
    tick();
    drive(1'b0, 32'd0);
    #1;
    checks++; if (pending_mask !== 32'h10) begin errors++; $display("FAIL b2b_mask_after: got %h want 10", pending_mask); end
    drain();
  endtask

  task automatic test_raw_adjacent();
    drive(1'b1, enc(6'd1, 5'd3, 5'd1, 5'd2));
    tick();
    drive(1'b1, enc(6'd3, 5'd5, 5'd3, 5'd4));
    for (int c = 1; c <= 2; c++) begin
      #1;
      checks++; if (stall !== 1'b1 || idex_bubble !== 1'b1) begin
        errors++; $display("FAIL raw_stall_t%0d: got stall=%b bub=%b want 1/1", c, stall, idex_bubble); end
      exp_sc++;
      tick();
    end
    #1;
    checks++; if (issue !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL raw_issue_t3: got issue=%b stall=%b want 1/0", issue, stall); end
    checks++; if (stall_count !== 16'(exp_sc)) begin errors++; $display("FAIL raw_count: got %0d want %0d", stall_count, exp_sc); end
    drain();
  endtask

  task automatic test_r0();
    drive(1'b1, enc(6'd1, 5'd0, 5'd1, 5'd2));
    tick();
    drive(1'b1, enc(6'd4, 5'd6, 5'd0, 5'd0));
    #1;
    checks++; if (stall !== 1'b0 || issue !== 1'b1 || pending_mask !== 32'd0) begin
      errors++; $display("FAIL r0_or: got stall=%b issue=%b mask=%h want 0/1/0", stall, issue, pending_mask); end
    tick();
    drive(1'b0, 32'd0);
    #1;
    checks++; if (pending_mask !== 32'h40) begin errors++; $display("FAIL r0_mask: got %h want 40", pending_mask); end
    drain();
  endtask

  task automatic test_idle();
    drive(1'b1, enc(6'd1, 5'd3, 5'd1, 5'd2));
    tick();
    drive(1'b0, enc(6'd3, 5'd5, 5'd3, 5'd4));
    #1;
    checks++; if (stall !== 1'b0 || issue !== 1'b0) begin errors++; $display("FAIL idle_dep: got stall=%b issue=%b want 0/0", stall, issue); end
    tick();
    tick();
    #1;
    checks++; if (pending_mask !== 32'h8) begin errors++; $display("FAIL idle_decrement: got %h want 8", pending_mask); end
    drain();
  endtask

  task automatic test_rewrite();
    drive(1'b1, enc(6'd1, 5'd3, 5'd1, 5'd2));
    tick();
    drive(1'b1, enc(6'd2, 5'd3, 5'd1, 5'd2));
    #1;
    checks++; if (issue !== 1'b1) begin errors++; $display("FAIL rw_second_issue: got %b want 1", issue); end
    tick();
    drive(1'b0, 32'd0);
    tick();
    drive(1'b1, enc(6'd4, 5'd7, 5'd3, 5'd1));
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rw_stall_t3: got %b want 1", stall); end
    exp_sc++;
    tick();
    #1;
    checks++; if (issue !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL rw_issue_t4: got issue=%b stall=%b want 1/0", issue, stall); end
    drain();
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, enc(6'd1, 5'd3, 5'd1, 5'd2));
    tick();
    drive(1'b1, enc(6'd3, 5'd5, 5'd3, 5'd4));
    tick();
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mid_pre_stall: got %b want 1", stall); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (stall !== 1'b0 || pending_mask !== 32'd0 || stall_count !== 16'd0) begin
      errors++; $display("FAIL mid_reset: got stall=%b mask=%h cnt=%0d want 0/0/0", stall, pending_mask, stall_count); end
    exp_sc = 0;
    #1;
    rst = 1'b0;
    #1;
    checks++; if (issue !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL mid_release: got issue=%b stall=%b want 1/0", issue, stall); end
    tick();
    drive(1'b0, 32'd0);
    #1;
    checks++; if (pending_mask !== 32'h20) begin errors++; $display("FAIL mid_and_issued: got %h want 20", pending_mask); end
    drain();
  endtask

  task automatic test_saturation();
    for (int k = 1; k <= 11; k++) begin
      drive(1'b1, enc(6'd1, 5'd3, 5'd1, 5'd2));
      tick();
      drive(1'b1, enc(6'd3, 5'd5, 5'd3, 5'd4));
      tick();
      tick();
      tick();
      exp_sc += 2;
      if (k == 7) begin
        checks++; if (s_stall_count !== 4'd14) begin errors++; $display("FAIL sat_mid: got %0d want 14", s_stall_count); end
      end
    end
    drive(1'b0, 32'd0);
    #1;
    checks++; if (s_stall_count !== 4'hF) begin errors++; $display("FAIL sat_hold: got %0d want 15", s_stall_count); end
    checks++; if (stall_count !== 16'(exp_sc)) begin errors++; $display("FAIL sat_wide: got %0d want %0d", stall_count, exp_sc); end
    drain();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_raw_adjacent();
    test_r0();
    test_idle();
    test_rewrite();
    test_reset_mid_stall();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
